ram_arbiter: RTL and testbench
==============================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset: clock  input  1  rising-edge clock for all state; reset  input  1  synchronous active-high reset.
REQ-002 The module SHALL provide, per requester i in {0,1}: req_i  input  1  access request; we_i  input  1  1=write, 0=read; addr_i  input  5  word address; wdata_i  input  32  write data; gnt_i  output  1  access performed this cycle; rdata_i  output  32  read data; rvalid_i  output  1  rdata_i valid.
REQ-003 The module SHALL provide on the RAM side: ram_chip_select  output  1; ram_we  output  1; ram_address  output  5; ram_data_in  output  32; ram_data_out  input  32, where the RAM reads combinationally and writes on the rising clock edge.

Function
REQ-004 The FSM states SHALL be IDLE, GRANT0 and GRANT1, registered; gnt_0=1 only in GRANT0, gnt_1=1 only in GRANT1.
REQ-005 Next-state arbitration each edge: no req -> IDLE; one req -> that port's GRANT; both req -> the port not equal to last_served (round-robin).
REQ-006 last_served SHALL update to the granted port on every edge at which a grant cycle completes with req_i=1.
REQ-007 A requester holding req_i across consecutive edges SHALL receive back-to-back grants only if the other port is not requesting.
REQ-008 In GRANTi, ram_chip_select SHALL equal req_i and not reset; ram_we = we_i and ram_chip_select; ram_address = addr_i; ram_data_in = wdata_i; in IDLE all RAM outputs SHALL be 0.
REQ-009 The transfer SHALL occur at the edge ending a cycle with gnt_i=1 and req_i=1; requester SHALL hold we_i/addr_i/wdata_i stable while req_i=1.
REQ-010 Read latency: for a read transfer, rdata_i SHALL be loaded with ram_data_out at the transfer edge and rvalid_i SHALL be 1 for exactly the following cycle.
REQ-011 rdata_i SHALL hold its last value otherwise; rvalid_i SHALL be 0 after writes and idle cycles.
REQ-012 If req_i drops during GRANTi, no RAM access and no rvalid_i SHALL result, and arbitration proceeds per REQ-005.
REQ-013 A request SHALL be granted within 2 cycles of assertion when held (no starvation).

Reset
REQ-014 While reset=1 at an edge: state=IDLE, last_served=1, gnt_0/1=0, rvalid_0/1=0, rdata_0/1=0.
REQ-015 A grant in progress when reset asserts SHALL be abandoned; no RAM write SHALL commit at that edge (ram_chip_select gated by reset).

Configuration
REQ-016 With RAM_ARB_FIXED_PRIORITY_EN defined, port 0 SHALL always win simultaneous requests and last_served is unused; without it, round-robin per REQ-005 applies.

Structure
REQ-017 Package ram_arb_pkg SHALL hold ADDR_W=5, DATA_W=32, state enum (IDLE, GRANT0, GRANT1) and port-id constants.
REQ-018 One sub-module rr_pick SHALL compute the 2-way winner from req_0, req_1, last_served and the priority mode.

Verification
REQ-019 Reset then idle -> all outputs 0, ram_chip_select=0 for 10 cycles.
REQ-020 Port 0 writes 0xDEADBEEF to addr 3, then reads addr 3 -> gnt_0 one cycle each, rvalid_0=1 one cycle after read transfer, rdata_0=0xDEADBEEF.
REQ-021 Both ports hold req for 6 cycles from reset -> grants alternate 0,1,0,1,0,1.
REQ-022 Same as REQ-021 with RAM_ARB_FIXED_PRIORITY_EN -> gnt_0 all 6 cycles, gnt_1 never.
REQ-023 Reset asserted during GRANT1 write of 0x12345678 to addr 7 -> addr 7 unchanged; gnt_1=0, rvalid_1=0 next cycle.
REQ-024 Port 1 drops req_1 while in GRANT1 (read, addr 9) -> ram_chip_select=0, no rvalid_1 pulse.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared widths, FSM state encoding and port identifiers for the RAM arbiter
package ram_arb_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
    function automatic state_t grant_of(input logic port);
        return port ? GRANT1 : GRANT0;
    endfunction
endpackage

// File: rtl/ram_arbiter_rr_pick.sv
// rr_pick: two-way winner selection, round-robin on last_served or fixed port-0 priority
module rr_pick
    import ram_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic req_0,
    input  logic req_1,
    input  logic last_served,
    output logic valid,
    output logic winner
);
    always_comb begin
        valid  = req_0 | req_1;
        winner = (req_0 & req_1) ? (FIXED_PRIO ? PORT0 : ~last_served) : (req_1 ? PORT1 : PORT0);
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-requester single-port RAM arbiter; define RAM_ARB_FIXED_PRIORITY_EN for fixed port-0 priority
module ram_arbiter
    import ram_arb_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              req_0,
    input  logic              we_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    output logic              gnt_0,
    output logic [DATA_W-1:0] rdata_0,
    output logic              rvalid_0,
    input  logic              req_1,
    input  logic              we_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_1,
    output logic [DATA_W-1:0] rdata_1,
    output logic              rvalid_1,
    output logic              ram_chip_select,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data_in,
    input  logic [DATA_W-1:0] ram_data_out
);
`ifdef RAM_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif
    state_t state, state_nxt;
    logic last_served, ls_eff, done_0, done_1, pick_valid, pick_winner;
    // A grant finishing at this edge counts as already served, so a held request yields to the other port
    always_comb begin
        done_0 = (state == GRANT0) & req_0;
        done_1 = (state == GRANT1) & req_1;
        ls_eff = done_0 ? PORT0 : done_1 ? PORT1 : last_served;
    end
    rr_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
        .req_0       (req_0),
        .req_1       (req_1),
        .last_served (ls_eff),
        .valid       (pick_valid),
        .winner      (pick_winner)
    );
    always_comb state_nxt = pick_valid ? grant_of(pick_winner) : IDLE;
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            last_served <= PORT1;
        end else begin
            state       <= state_nxt;
            last_served <= ls_eff;
        end
    end
    always_comb begin
        gnt_0           = state == GRANT0;
        gnt_1           = state == GRANT1;
        ram_chip_select = ((gnt_0 & req_0) | (gnt_1 & req_1)) & ~reset;
        ram_we          = ram_chip_select & (gnt_1 ? we_1 : we_0);
        ram_address     = gnt_0 ? addr_0 : gnt_1 ? addr_1 : '0;
        ram_data_in     = gnt_0 ? wdata_0 : gnt_1 ? wdata_1 : '0;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            rvalid_0 <= 1'b0;
            rvalid_1 <= 1'b0;
            rdata_0  <= '0;
            rdata_1  <= '0;
        end else begin
            rvalid_0 <= done_0 & ~we_0;
            rvalid_1 <= done_1 & ~we_1;
            if (done_0 & ~we_0) rdata_0 <= ram_data_out;
            if (done_1 & ~we_1) rdata_1 <= ram_data_out;
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scoreboard bench for ram_arbiter with a behavioural RAM
module tb_ram_arbiter;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_0, we_0, req_1, we_1;
    logic [4:0]  addr_0, addr_1;
    logic [31:0] wdata_0, wdata_1;
    logic        gnt_0, gnt_1, rvalid_0, rvalid_1;
    logic [31:0] rdata_0, rdata_1;
    logic        ram_chip_select, ram_we;
    logic [4:0]  ram_address;
    logic [31:0] ram_data_in, ram_data_out;
    logic [31:0] mem [32];
    logic [31:0] ref_mem [32];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    bit          seeded = 1'b0;
    int          passed = 0;
    int          failed = 0;
    int          total = 0;
    bit          exp_p;
`ifdef RAM_ARB_FIXED_PRIORITY_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    ram_arbiter dut (
        .clock(clock), .reset(reset),
        .req_0(req_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
        .gnt_0(gnt_0), .rdata_0(rdata_0), .rvalid_0(rvalid_0),
        .req_1(req_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
        .gnt_1(gnt_1), .rdata_1(rdata_1), .rvalid_1(rvalid_1),
        .ram_chip_select(ram_chip_select), .ram_we(ram_we), .ram_address(ram_address),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] seed(input int k);
        return 32'hA5A5_0000 | 32'(k);
    endfunction

    assign ram_data_out = mem[ram_address];
    always @(posedge clock) begin
        if (!seeded) begin
            for (int k = 0; k < 32; k++) mem[k] <= seed(k);
            seeded <= 1'b1;
        end else if (ram_chip_select && ram_we) begin
            mem[ram_address] <= ram_data_in;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (rvalid_0) begin
            if (q0.size() == 0) chk("rvalid_0_unexpected", 64'(rvalid_0), 64'(0));
            else chk("rdata_0", 64'(rdata_0), 64'(q0.pop_front()));
        end
        if (rvalid_1) begin
            if (q1.size() == 0) chk("rvalid_1_unexpected", 64'(rvalid_1), 64'(0));
            else chk("rdata_1", 64'(rdata_1), 64'(q1.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 32; k++) ref_mem[k] = seed(k);
        reset = 1'b1;
        {req_0, we_0, addr_0, wdata_0} = '0;
        {req_1, we_1, addr_1, wdata_1} = '0;
        repeat (2) tick();
        chk("rst_gnt", 64'({gnt_1, gnt_0}), 64'(0));
        chk("rst_rvalid", 64'({rvalid_1, rvalid_0}), 64'(0));
        chk("rst_rdata", {rdata_1, rdata_0}, 64'(0));
        reset = 1'b0;
        repeat (10) begin
            tick();
            @(negedge clock);
            chk("idle_ram", 64'({ram_chip_select, ram_we, ram_address, ram_data_in}), 64'(0));
            chk("idle_out", 64'({gnt_1, gnt_0, rvalid_1, rvalid_0}), 64'(0));
        end
        tick();
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 5'd3; wdata_0 = 32'hDEADBEEF;
        ref_mem[3] = 32'hDEADBEEF;
        tick();
        @(negedge clock);
        chk("wr_gnt", 64'({gnt_1, gnt_0}), 64'(2'b01));
        chk("wr_bus", 64'({ram_chip_select, ram_we, ram_address, ram_data_in}), {25'd0, 1'b1, 1'b1, 5'd3, 32'hDEADBEEF});
        tick();
        we_0 = 1'b0;
        q0.push_back(ref_mem[3]);
        @(negedge clock);
        chk("rd_gnt", 64'({gnt_1, gnt_0}), 64'(2'b01));
        chk("rd_bus", 64'({ram_chip_select, ram_we, ram_address}), 64'({1'b1, 1'b0, 5'd3}));
        chk("mem3_written", 64'(mem[3]), 64'(32'hDEADBEEF));
        chk("rvalid_after_wr", 64'(rvalid_0), 64'(0));
        tick();
        req_0 = 1'b0;
        @(negedge clock);
        chk("rvalid_0_pulse", 64'(rvalid_0), 64'(1));
        chk("cs_after_drop", 64'(ram_chip_select), 64'(0));
        tick();
        @(negedge clock);
        chk("rvalid_0_end", 64'(rvalid_0), 64'(0));
        chk("rdata_0_hold", 64'(rdata_0), 64'(32'hDEADBEEF));
        chk("idle_after_rd", 64'({gnt_1, gnt_0}), 64'(0));
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_0 = 1'b1; addr_0 = 5'd5; we_0 = 1'b0;
        req_1 = 1'b1; addr_1 = 5'd6; we_1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_p = FIXED ? 1'b0 : 1'(i % 2);
            @(negedge clock);
            chk($sformatf("both_gnt_%0d", i), 64'({gnt_1, gnt_0}), exp_p ? 64'(2'b10) : 64'(2'b01));
            if (exp_p) q1.push_back(ref_mem[6]);
            else q0.push_back(ref_mem[5]);
        end
        tick();
        req_0 = 1'b0; req_1 = 1'b0;
        repeat (3) tick();
        chk("both_drain", {32'(q1.size()), 32'(q0.size())}, 64'(0));
        req_1 = 1'b1; we_1 = 1'b1; addr_1 = 5'd7; wdata_1 = 32'h12345678;
        tick();
        reset = 1'b1;
        @(negedge clock);
        chk("rst_gnt1_active", 64'(gnt_1), 64'(1));
        chk("rst_cs_gated", 64'(ram_chip_select), 64'(0));
        tick();
        chk("mem7_kept", 64'(mem[7]), 64'(seed(7)));
        chk("rst_gnt1_off", 64'({gnt_1, rvalid_1}), 64'(0));
        reset = 1'b0; req_1 = 1'b0; we_1 = 1'b0;
        tick();
        req_1 = 1'b1; addr_1 = 5'd9;
        tick();
        req_1 = 1'b0;
        @(negedge clock);
        chk("drop_gnt1", 64'(gnt_1), 64'(1));
        chk("drop_cs", 64'(ram_chip_select), 64'(0));
        tick();
        chk("drop_no_rvalid", 64'({gnt_1, rvalid_1}), 64'(0));
        tick();
        chk("drop_no_rvalid2", 64'(rvalid_1), 64'(0));
        repeat (2) tick();
        chk("final_drain", {32'(q1.size()), 32'(q0.size())}, 64'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
